// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// State enum, opcode values, datapath select codes and trap causes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_ALU_WB,
    S_ADDI_EXEC,
    S_ADDI_WB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  // True in the last cycle of an instruction, where it retires.
  function automatic logic is_end(state_t s, logic mem_ready);
    return (s inside {S_MEM_WB, S_ALU_WB, S_ADDI_WB,
                      S_BRANCH, S_JUMP})
        || (s == S_MEM_WRITE && mem_ready);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core.
// Sequences ALU, memory, IR and regfile; traps on bad opcodes/timeouts.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic [5:0]       opcode,
  input  logic             zeroflag,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int WC_W = $clog2(WAIT_TIMEOUT + 1);

  state_t          state, state_d;
  logic [1:0]      cause_d;
  logic [WC_W-1:0] wcnt;
  logic            wait_st;
  logic            timeout;
  logic            end_cyc;

  // zeroflag gates the PC write in the datapath, not here.
  logic unused_zeroflag;
  assign unused_zeroflag = zeroflag;

  assign wait_st = state inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
  assign timeout = wait_st && !mem_ready
                && (wcnt == WC_W'(WAIT_TIMEOUT - 1));
  assign end_cyc = is_end(state, mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      trap_cause <= TRAP_NONE;
    end else begin
      state      <= state_d;
      trap_cause <= cause_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state_d != state)
      wcnt <= '0;
    else if (wait_st && !mem_ready)
      wcnt <= wcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      instret <= '0;
    else if (end_cyc)
      instret <= instret + CNT_W'(1);
  end

  always_comb begin
    state_d = state;
    cause_d = trap_cause;
    unique case (state)
      S_IDLE:
        if (start) state_d = S_FETCH;
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      S_DECODE:
        unique case (1'b1)
          (opcode == OP_RTYPE): state_d = S_EXEC_R;
          (opcode == OP_LW),
          (opcode == OP_SW):    state_d = S_MEM_ADDR;
          (opcode == OP_BEQ):   state_d = S_BRANCH;
          (opcode == OP_J):     state_d = S_JUMP;
          (opcode == OP_ADDI):  state_d = S_ADDI_EXEC;
          default: begin
            state_d = S_TRAP;
            cause_d = TRAP_ILLEGAL;
          end
        endcase
      S_MEM_ADDR:
        state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:
        if (mem_ready) state_d = S_MEM_WB;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      S_MEM_WRITE:
        if (!mem_ready && timeout) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      S_EXEC_R:    state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default: ;
    endcase
    if (end_cyc)
      state_d = halt ? S_IDLE : S_FETCH;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REGB;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    busy        = !(state inside {S_IDLE, S_TRAP});
    trap        = (state == S_TRAP);
    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:
        ALUSrcB = SRCB_IMM_SH;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_ADDI_WB:
        RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: directed scenarios then random
// instruction streams, checked cycle by cycle against a step-table model.
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_ADDI  = 6'b001000;

  typedef enum {T_IDLE, T_F, T_D, T_MA, T_MR, T_MWB, T_MW,
                T_XR, T_AWB, T_XI, T_IWB, T_BR, T_J_ST, T_TRAP} step_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic halt = 1'b0;
  logic [5:0] opcode = '0;
  logic zeroflag = 1'b0;
  logic mem_ready = 1'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic busy, trap;
  logic [1:0] trap_cause;
  logic [CNT_W-1:0] instret;

  int total = 0;
  int bad = 0;
  int exp_instret = 0;
  logic [1:0] exp_cause = 2'b00;
  bit in_idle = 1'b1;
  bit trapped = 1'b0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.WAIT_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .opcode(opcode), .zeroflag(zeroflag), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .busy(busy), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  logic [17:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                PCSource, busy, trap};

  // Expected control pattern for one step of an instruction.
  function automatic logic [17:0] exp_vec(step_t s, bit mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      T_F:    begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      T_D:    srcb = 2'b11;
      T_MA:   begin srca = 1; srcb = 2'b10; end
      T_MR:   begin mrd = 1; iord = 1; end
      T_MWB:  begin m2r = 1; rw = 1; end
      T_MW:   begin mwr = 1; iord = 1; end
      T_XR:   begin srca = 1; aop = 2'b10; end
      T_AWB:  begin rdst = 1; rw = 1; end
      T_XI:   begin srca = 1; srcb = 2'b10; end
      T_IWB:  rw = 1;
      T_BR:   begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      T_J_ST: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
            srcb, aop, pcs,
            1'(!(s inside {T_IDLE, T_TRAP})), 1'(s == T_TRAP)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, o, e);
      $error("%s check", tag);
    end
  endtask

  task automatic cycle(input step_t s, input bit mr, input logic [5:0] op,
                       input bit zf, input bit hl, input bit st);
    @(posedge clk); #1;
    opcode = op; zeroflag = zf; mem_ready = mr; halt = hl; start = st;
    #1;
    chk($sformatf("ctrl_%s", s.name()), 32'(obs), 32'(exp_vec(s, mr)));
    chk("instret", 32'(instret), 32'(exp_instret));
    chk("trap_cause", 32'(trap_cause), 32'(exp_cause));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; halt = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_instret = 0; exp_cause = 2'b00;
    in_idle = 1'b1; trapped = 1'b0;
    #1;
    chk("rst_ctrl", 32'(obs), 32'(exp_vec(T_IDLE, 1'b0)));
    chk("rst_instret", 32'(instret), 0);
    chk("rst_cause", 32'(trap_cause), 0);
  endtask

  // One instruction: fs/ms stall counts (16 forces a timeout),
  // cut>0 stops after that many steps without retiring.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms,
                           input bit zf, input bit hlt, input int cut);
    step_t sq[$];
    bit mq[$];
    logic [1:0] cause = 2'b00;
    int n;
    if (in_idle)
      cycle(T_IDLE, 1'($urandom), 6'($urandom), 1'($urandom), 1'b0, 1'b1);
    in_idle = 1'b0;
    repeat ((fs >= 16) ? 16 : fs) begin sq.push_back(T_F); mq.push_back(0); end
    if (fs >= 16) cause = 2'b10;
    else begin
      sq.push_back(T_F); mq.push_back(1);
      sq.push_back(T_D); mq.push_back(1'($urandom));
      case (op)
        T_LW, T_SW: begin
          sq.push_back(T_MA); mq.push_back(1'($urandom));
          repeat ((ms >= 16) ? 16 : ms) begin
            sq.push_back(op == T_LW ? T_MR : T_MW); mq.push_back(0);
          end
          if (ms >= 16) cause = 2'b10;
          else if (op == T_LW) begin
            sq.push_back(T_MR); mq.push_back(1);
            sq.push_back(T_MWB); mq.push_back(1'($urandom));
          end else begin
            sq.push_back(T_MW); mq.push_back(1);
          end
        end
        T_RTYPE: begin
          sq.push_back(T_XR); mq.push_back(1'($urandom));
          sq.push_back(T_AWB); mq.push_back(1'($urandom));
        end
        T_ADDI: begin
          sq.push_back(T_XI); mq.push_back(1'($urandom));
          sq.push_back(T_IWB); mq.push_back(1'($urandom));
        end
        T_BEQ: begin sq.push_back(T_BR); mq.push_back(1'($urandom)); end
        T_J: begin sq.push_back(T_J_ST); mq.push_back(1'($urandom)); end
        default: cause = 2'b01;
      endcase
    end
    n = (cut > 0 && cut < sq.size()) ? cut : sq.size();
    for (int i = 0; i < n; i++) begin
      bit last = (i == sq.size() - 1) && (cause == 2'b00);
      cycle(sq[i], mq[i], (sq[i] == T_F) ? 6'($urandom) : op, zf,
            last ? hlt : 1'($urandom), 1'($urandom));
    end
    if (cut > 0) return;
    if (cause != 2'b00) begin
      exp_cause = cause;
      trapped = 1'b1;
      repeat (3)
        cycle(T_TRAP, 1'($urandom), 6'($urandom), 1'($urandom),
              1'($urandom), 1'b1);
    end else begin
      exp_instret = (exp_instret + 1) % (1 << CNT_W);
      in_idle = hlt;
    end
  endtask

  initial begin
    logic [5:0] op;
    int k;
    do_reset();
    run_instr(T_ADDI, 0, 0, 0, 0, 0);
    run_instr(T_LW, 0, 3, 0, 0, 0);
    run_instr(T_BEQ, 0, 0, 1, 0, 0);
    run_instr(T_BEQ, 0, 0, 0, 0, 0);
    run_instr(T_J, 0, 0, 0, 1, 0);
    run_instr(T_RTYPE, 1, 0, 0, 0, 0);
    run_instr(T_SW, 0, 2, 0, 0, 5);
    do_reset();
    run_instr(6'b111111, 0, 0, 0, 0, 0);
    do_reset();
    run_instr(T_RTYPE, 16, 0, 0, 0, 0);
    do_reset();
    run_instr(T_SW, 0, 15, 0, 0, 0);
    run_instr(T_LW, 0, 16, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 19);
      if (k < 4) op = T_RTYPE;
      else if (k < 7) op = T_LW;
      else if (k < 10) op = T_SW;
      else if (k < 13) op = T_BEQ;
      else if (k < 15) op = T_J;
      else if (k < 19) op = T_ADDI;
      else begin
        op = 6'($urandom);
        while (op inside {T_RTYPE, T_LW, T_SW, T_BEQ, T_J, T_ADDI})
          op = 6'($urandom);
      end
      run_instr(op,
                ($urandom_range(0, 29) == 0) ? 16 : $urandom_range(0, 3),
                ($urandom_range(0, 19) == 0) ? 16 : $urandom_range(0, 4),
                1'($urandom), ($urandom_range(0, 3) == 0), 0);
      if (trapped) do_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
